mul_issue_ctrl: RTL and testbench
=================================

# mul_issue_ctrl

Issue controller and result scheduler for the shared 8-stage pipelined multiplier (`mult`). It arbitrates round-robin among `NUM_REQ` multiply reservation-station ports and accepts up to one operation per cycle. It converts signed operands to magnitudes and tracks each in-flight operation's tags in a pipeline aligned with the multiplier. On return it applies sign correction and result selection, then buffers results in a FIFO for the CDB, using credit-based issue so that no result is ever dropped under CDB backpressure.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesting RS ports.
- `LATENCY`, 8: multiplier start-to-product latency in cycles; must equal the multiplier's `STAGE`.
- `FIFO_DEPTH`, 10: result FIFO entries; must be ≥ 1. Full throughput needs ≥ `LATENCY`+2.
- `XLEN`, 32; `PRF_LEN`, 6; `ROB_LEN`, 5.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  `NUM_REQ`  request pending per port.
- `req_opa`, `req_opb`  in  `NUM_REQ*XLEN`  operands, port i at [i*XLEN +: XLEN].
- `req_func`  in  `NUM_REQ*2`  function code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
- `req_prf_idx`  in  `NUM_REQ*PRF_LEN`  destination physical register tag.
- `req_rob_idx`  in  `NUM_REQ*ROB_LEN`  ROB tag.
- `req_ready`  out  `NUM_REQ`  one-hot grant; the request is accepted in the same cycle.
- `squash`  in  1  flush of all in-flight and buffered operations.
- `mult_start`  out  1  start pulse to the multiplier.
- `mult_mcand`, `mult_mplier`  out  `2*XLEN`  zero-extended operand magnitudes.
- `mult_product`  in  `2*XLEN`  multiplier product.
- `cdb_valid`  out  1  FIFO head valid.
- `cdb_value`  out  `XLEN`  result value.
- `cdb_prf_idx`  out  `PRF_LEN`  head destination register tag.
- `cdb_rob_idx`  out  `ROB_LEN`  head ROB tag.
- `cdb_grant`  in  1  CDB accepts the head this cycle.
- `busy`  out  1  outstanding count ≠ 0.

## Operation
- `outstanding` = (valid tag-pipe entries) + `fifo_count`.
- Issue is allowed when `outstanding < FIFO_DEPTH`, `squash`=0 and `reset`=0. Credit freed by a same-cycle pop is not reused until the next cycle.
- Arbitration is round-robin. Pointer `rr` resets to 0. Grant the first valid port at or after `rr`, modulo `NUM_REQ`. After a grant to port i, `rr` ← (i+1) mod `NUM_REQ`. With no grant, `rr` holds.
- `mult_start` = OR of `req_ready`.
- Operand conversion for the granted port:
  - `sa` = `opa[XLEN-1]` when func ∈ {0,1,2}; else 0.
  - `sb` = `opb[XLEN-1]` when func ∈ {0,1}; else 0.
  - Each operand's magnitude is its 2's-complement negation when the sign flag is set; otherwise the raw value. The magnitude is zero-extended to `2*XLEN`.
  - `neg` = `sa` XOR `sb`.
- With no grant, `mult_mcand` and `mult_mplier` are driven to 0.
- Tag pipe: `LATENCY` registered entries, each {valid, func, neg, prf, rob}. Entry 0 is loaded at issue. An entry exits from stage `LATENCY`-1 in the same cycle `mult_product` belongs to it.
- Result formation at exit:
  - P = `neg` ? (~`mult_product`+1) : `mult_product`, computed modulo 2^(2*XLEN).
  - func 0 selects P[XLEN-1:0]; func 1–3 select P[2*XLEN-1:XLEN].
  - Example: −1 × −1 MULH = 0; −1 × 1 MULH = 0xFFFFFFFF (XLEN=32).
- FIFO: the exiting valid entry is written at that clock edge. The head is popped on `cdb_valid & cdb_grant`. A simultaneous push and pop are both honoured.
- Pointers wrap from `FIFO_DEPTH`-1 to 0. The credit rule guarantees no push occurs when the FIFO is full. A push to a full FIFO is a design error and is flagged by a simulation assertion.
- `squash`:
  - At the next edge, clear all tag-pipe valid bits and empty the FIFO.
  - No grant is made in the squash cycle.
  - `rr` is unchanged.
  - Products still inside the multiplier are discarded, because their tags are invalid.
  - A pop and a squash in the same cycle: the pop completes and the FIFO then ends empty.

## Timing
- Reset values: `cdb_valid`=0, `busy`=0, FIFO empty, tag pipe invalid, `rr`=0. While `reset`=1, `req_ready`=0 and `mult_start`=0.
- Request-to-grant is combinational, cycle T.
- The product exits at T+`LATENCY`. With the FIFO empty, `cdb_valid`=1 from T+`LATENCY`+1. Total latency is `LATENCY`+1 cycles.
- Sustained throughput is one operation per cycle with `cdb_grant` held high and `FIFO_DEPTH` ≥ `LATENCY`+2.
- `cdb_*` are registered FIFO outputs. They hold stable while `cdb_valid`=1 and `cdb_grant`=0.

## Test plan
- Single MUL, port 0, opa=7, opb=−3, `cdb_grant`=1 → `cdb_valid` at T+9 with value 0xFFFFFFEB and the correct prf/rob tags; `busy` falls afterwards.
- Each func with opa=0x80000000, opb=0xFFFFFFFF:
  - MUL → 0x80000000.
  - MULH → 0x00000000.
  - MULHSU → 0x80000000.
  - MULHU → 0x7FFFFFFF.
- Both ports request continuously → grants alternate 0,1,0,1; one issue per cycle; results return in issue order.
- Hold `cdb_grant`=0 with continuous requests → exactly 10 operations accepted, then `req_ready`=0. After grant is restored, all 10 results drain in order with no loss, and issue resumes.
- Assert `squash` with 5 in flight and 3 buffered → `cdb_valid`=0 next cycle; no stale results ever appear. A new operation issued 1 cycle later returns correctly at +9.
- Assert `reset` mid-stream → all outputs return to their reset values next cycle and `rr`=0.

Source files
------------

// File: rtl/mul_issue_ctrl_if.sv
// Bundle of request, multiplier and CDB signals between the RS ports and the issue controller.
interface mul_issue_ctrl_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PRF_LEN = 6,
    parameter int unsigned ROB_LEN = 5
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*XLEN-1:0]    req_opa;
    logic [NUM_REQ*XLEN-1:0]    req_opb;
    logic [NUM_REQ*2-1:0]       req_func;
    logic [NUM_REQ*PRF_LEN-1:0] req_prf_idx;
    logic [NUM_REQ*ROB_LEN-1:0] req_rob_idx;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       squash;
    logic                       mult_start;
    logic [2*XLEN-1:0]          mult_mcand;
    logic [2*XLEN-1:0]          mult_mplier;
    logic [2*XLEN-1:0]          mult_product;
    logic                       cdb_valid;
    logic [XLEN-1:0]            cdb_value;
    logic [PRF_LEN-1:0]         cdb_prf_idx;
    logic [ROB_LEN-1:0]         cdb_rob_idx;
    logic                       cdb_grant;
    logic                       busy;

    // Environment side: RS ports, multiplier and CDB
    modport master (
        output req_valid, req_opa, req_opb, req_func, req_prf_idx, req_rob_idx,
        output squash, mult_product, cdb_grant,
        input  req_ready, mult_start, mult_mcand, mult_mplier,
        input  cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, busy
    );

    // Controller side
    modport slave (
        input  req_valid, req_opa, req_opb, req_func, req_prf_idx, req_rob_idx,
        input  squash, mult_product, cdb_grant,
        output req_ready, mult_start, mult_mcand, mult_mplier,
        output cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, busy
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the shared pipelined multiplier: round-robin grant, sign stripping,
// tag tracking aligned with the multiplier, sign fix-up and a credit-guarded result FIFO.
module mul_issue_ctrl #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned FIFO_DEPTH = 10,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PRF_LEN    = 6,
    parameter int unsigned ROB_LEN    = 5
) (
    input logic           clock,
    input logic           reset,
    mul_issue_ctrl_if.slave io_bus
);
    localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(LATENCY + FIFO_DEPTH + 1);

    logic [LATENCY-1:0] r_tp_valid;
    logic [LATENCY-1:0] r_tp_neg;
    logic [1:0]         r_tp_func [LATENCY];
    logic [PRF_LEN-1:0] r_tp_prf  [LATENCY];
    logic [ROB_LEN-1:0] r_tp_rob  [LATENCY];

    logic [XLEN-1:0]    r_fifo_value [FIFO_DEPTH];
    logic [PRF_LEN-1:0] r_fifo_prf   [FIFO_DEPTH];
    logic [ROB_LEN-1:0] r_fifo_rob   [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [RR_W-1:0]    r_rr;

    logic [OUT_W-1:0]   w_outstanding;
    logic               w_can_issue;
    logic               w_found;
    logic [RR_W-1:0]    w_sel;
    logic [NUM_REQ-1:0] w_grant;
    logic [XLEN-1:0]    w_opa, w_opb, w_mag_a, w_mag_b;
    logic [1:0]         w_func;
    logic               w_sa, w_sb;
    logic [PRF_LEN-1:0] w_prf;
    logic [ROB_LEN-1:0] w_rob;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_result;
    logic               w_push, w_pop;

    // Credit: every op in the tag pipe already owns a FIFO slot, so count both
    always_comb begin
        w_outstanding = OUT_W'(r_count);
        for (int unsigned i = 0; i < LATENCY; i++) begin
            w_outstanding = w_outstanding + OUT_W'(r_tp_valid[i]);
        end
    end

    assign w_can_issue = (w_outstanding < OUT_W'(FIFO_DEPTH)) && !io_bus.squash && !reset;

    // Round-robin search starting at r_rr, wrapping modulo NUM_REQ
    always_comb begin
        logic [RR_W:0]   sum;
        logic [RR_W-1:0] idx;
        sum     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_sel   = '0;
        w_grant = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, r_rr} + (RR_W+1)'(k);
            if (sum >= (RR_W+1)'(NUM_REQ)) begin
                sum = sum - (RR_W+1)'(NUM_REQ);
            end
            idx = sum[RR_W-1:0];
            if (!w_found && w_can_issue && io_bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
        if (w_found) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    // Select the granted port's fields and strip operand signs
    always_comb begin
        w_opa  = '0;
        w_opb  = '0;
        w_func = '0;
        w_prf  = '0;
        w_rob  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_sel == RR_W'(i)) begin
                w_opa  = io_bus.req_opa[i*XLEN +: XLEN];
                w_opb  = io_bus.req_opb[i*XLEN +: XLEN];
                w_func = io_bus.req_func[i*2 +: 2];
                w_prf  = io_bus.req_prf_idx[i*PRF_LEN +: PRF_LEN];
                w_rob  = io_bus.req_rob_idx[i*ROB_LEN +: ROB_LEN];
            end
        end
        // MULHU treats opa as unsigned; MULHSU and MULHU treat opb as unsigned
        w_sa    = (w_func != 2'd3) && w_opa[XLEN-1];
        w_sb    = !w_func[1] && w_opb[XLEN-1];
        w_mag_a = w_sa ? (~w_opa + XLEN'(1)) : w_opa;
        w_mag_b = w_sb ? (~w_opb + XLEN'(1)) : w_opb;
    end

    assign io_bus.req_ready   = w_grant;
    assign io_bus.mult_start  = w_found;
    assign io_bus.mult_mcand  = w_found ? {{XLEN{1'b0}}, w_mag_a} : '0;
    assign io_bus.mult_mplier = w_found ? {{XLEN{1'b0}}, w_mag_b} : '0;

    // Restore the sign of the returning product and pick the requested half
    always_comb begin
        w_prod   = r_tp_neg[LATENCY-1] ? (~io_bus.mult_product + (2*XLEN)'(1))
                                       : io_bus.mult_product;
        w_result = (r_tp_func[LATENCY-1] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    assign w_push = r_tp_valid[LATENCY-1] && !io_bus.squash;
    assign w_pop  = (r_count != '0) && io_bus.cdb_grant;

    // Arbitration pointer moves past the winner; holds otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr <= '0;
        end else if (w_found) begin
            r_rr <= (w_sel == RR_W'(NUM_REQ - 1)) ? '0 : w_sel + RR_W'(1);
        end
    end

    // Valid bits of the tag pipe; squash kills everything still inside the multiplier
    always_ff @(posedge clock) begin
        if (reset || io_bus.squash) begin
            r_tp_valid <= '0;
        end else begin
            r_tp_valid[0] <= w_found;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_tp_valid[i] <= r_tp_valid[i-1];
            end
        end
    end

    // Tag payload shifts unconditionally; it is only meaningful where valid is set
    always_ff @(posedge clock) begin
        r_tp_neg[0]  <= w_sa ^ w_sb;
        r_tp_func[0] <= w_func;
        r_tp_prf[0]  <= w_prf;
        r_tp_rob[0]  <= w_rob;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            r_tp_neg[i]  <= r_tp_neg[i-1];
            r_tp_func[i] <= r_tp_func[i-1];
            r_tp_prf[i]  <= r_tp_prf[i-1];
            r_tp_rob[i]  <= r_tp_rob[i-1];
        end
    end

    // FIFO pointers and occupancy; squash empties it even if a pop also happens
    always_ff @(posedge clock) begin
        if (reset || io_bus.squash) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // FIFO storage write
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_value[r_wr_ptr] <= w_result;
            r_fifo_prf[r_wr_ptr]   <= r_tp_prf[LATENCY-1];
            r_fifo_rob[r_wr_ptr]   <= r_tp_rob[LATENCY-1];
        end
    end

    assign io_bus.cdb_valid   = (r_count != '0);
    assign io_bus.cdb_value   = r_fifo_value[r_rd_ptr];
    assign io_bus.cdb_prf_idx = r_fifo_prf[r_rd_ptr];
    assign io_bus.cdb_rob_idx = r_fifo_rob[r_rd_ptr];
    assign io_bus.busy        = (w_outstanding != '0);

`ifndef SYNTHESIS
    // Credit accounting must make a push into a full FIFO impossible
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            assert (r_count < CNT_W'(FIFO_DEPTH))
            else $error("mul_issue_ctrl: push into full result FIFO");
        end
    end
`endif
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a behavioural multiplier and a queue-based model.
module tb_mul_issue_ctrl;
    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned LATENCY    = 8;
    localparam int unsigned FIFO_DEPTH = 10;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned PRF_LEN    = 6;
    localparam int unsigned ROB_LEN    = 5;

    logic clock;
    logic reset;

    mul_issue_ctrl_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .PRF_LEN(PRF_LEN), .ROB_LEN(ROB_LEN))
        bus ();

    mul_issue_ctrl #(
        .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH),
        .XLEN(XLEN), .PRF_LEN(PRF_LEN), .ROB_LEN(ROB_LEN)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural LATENCY-stage multiplier
    logic [2*XLEN-1:0] mpipe [LATENCY];
    always @(posedge clock) begin
        mpipe[0] <= bus.mult_mcand * bus.mult_mplier;
        for (int i = 1; i < int'(LATENCY); i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mult_product = mpipe[LATENCY-1];

    typedef struct {
        logic [31:0] value;
        logic [5:0]  prf;
        logic [4:0]  rob;
        int          ready;
    } exp_t;

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [1:0]  func;
        logic [31:0] expv;
    } vec_t;

    exp_t m_q[$];
    int   m_rr;
    int   m_cycle;
    int   n_checks;
    int   n_fail;

    logic        obs_valid;
    logic [31:0] obs_value;
    logic [5:0]  obs_prf;
    logic [4:0]  obs_rob;
    logic [1:0]  obs_ready;
    logic        obs_busy;

    // Reference result straight from signed/unsigned integer arithmetic
    function automatic logic [31:0] ref_result(logic [31:0] a, logic [31:0] b, logic [1:0] f);
        logic [63:0] ea, eb, full;
        ea   = (f != 2'd3) ? {{32{a[31]}}, a} : {32'b0, a};
        eb   = (f == 2'd0 || f == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        full = ea * eb;
        return (f == 2'd0) ? full[31:0] : full[63:32];
    endfunction

    function automatic logic [63:0] magnitude(logic [31:0] v, logic is_signed);
        if (is_signed && v[31]) return 64'h1_0000_0000 - {32'b0, v};
        return {32'b0, v};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, m_cycle);
        end
    endtask

    task automatic quiet();
        bus.req_valid   = '0;
        bus.req_opa     = '0;
        bus.req_opb     = '0;
        bus.req_func    = '0;
        bus.req_prf_idx = '0;
        bus.req_rob_idx = '0;
        bus.squash      = 1'b0;
        bus.cdb_grant   = 1'b1;
    endtask

    task automatic set_req(int p, logic [31:0] a, logic [31:0] b, logic [1:0] f,
                           logic [5:0] prf, logic [4:0] rob);
        bus.req_valid[p]                    = 1'b1;
        bus.req_opa[p*XLEN +: XLEN]         = a;
        bus.req_opb[p*XLEN +: XLEN]         = b;
        bus.req_func[p*2 +: 2]              = f;
        bus.req_prf_idx[p*PRF_LEN +: PRF_LEN] = prf;
        bus.req_rob_idx[p*ROB_LEN +: ROB_LEN] = rob;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_req(int all_valid);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            set_req(i, rand_operand(), rand_operand(), 2'($urandom_range(0, 3)),
                    6'($urandom), 5'($urandom));
            bus.req_valid[i] = (all_valid != 0) || ($urandom_range(0, 3) != 0);
        end
    endtask

    // One cycle: check outputs against the model at negedge, then advance the model
    task automatic step();
        int          g;
        int          p;
        logic [1:0]  exp_ready;
        logic [31:0] a, b;
        logic [1:0]  f;
        logic        ev;
        exp_t        e;
        @(negedge clock);
        g = -1;
        a = '0;
        b = '0;
        f = '0;
        exp_ready = '0;
        if (!reset && !bus.squash && m_q.size() < int'(FIFO_DEPTH)) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                p = (m_rr + k) % int'(NUM_REQ);
                if (g < 0 && bus.req_valid[p]) g = p;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("mult_start", 64'(bus.mult_start), 64'(g >= 0));
        if (g >= 0) begin
            a = bus.req_opa[g*XLEN +: XLEN];
            b = bus.req_opb[g*XLEN +: XLEN];
            f = bus.req_func[g*2 +: 2];
            check("mult_mcand", bus.mult_mcand, magnitude(a, f != 2'd3));
            check("mult_mplier", bus.mult_mplier, magnitude(b, f == 2'd0 || f == 2'd1));
        end else begin
            check("mult_mcand_idle", bus.mult_mcand, 64'h0);
            check("mult_mplier_idle", bus.mult_mplier, 64'h0);
        end
        ev = (m_q.size() > 0) && (m_q[0].ready <= m_cycle);
        check("cdb_valid", 64'(bus.cdb_valid), 64'(ev));
        if (ev) begin
            check("cdb_value", 64'(bus.cdb_value), 64'(m_q[0].value));
            check("cdb_prf_idx", 64'(bus.cdb_prf_idx), 64'(m_q[0].prf));
            check("cdb_rob_idx", 64'(bus.cdb_rob_idx), 64'(m_q[0].rob));
        end
        check("busy", 64'(bus.busy), 64'(m_q.size() != 0));
        obs_valid = bus.cdb_valid;
        obs_value = bus.cdb_value;
        obs_prf   = bus.cdb_prf_idx;
        obs_rob   = bus.cdb_rob_idx;
        obs_ready = bus.req_ready;
        obs_busy  = bus.busy;
        if (reset) begin
            m_q.delete();
            m_rr = 0;
        end else begin
            if (ev && bus.cdb_grant) void'(m_q.pop_front());
            if (bus.squash) begin
                m_q.delete();
            end else if (g >= 0) begin
                e.value = ref_result(a, b, f);
                e.prf   = bus.req_prf_idx[g*PRF_LEN +: PRF_LEN];
                e.rob   = bus.req_rob_idx[g*ROB_LEN +: ROB_LEN];
                e.ready = m_cycle + int'(LATENCY) + 1;
                m_q.push_back(e);
                m_rr = (g + 1) % int'(NUM_REQ);
            end
        end
        m_cycle++;
        @(posedge clock);
        #1;
    endtask

    // Waits for the head result; returns cycles waited (0 if it never showed)
    task automatic wait_result(output int lat);
        int got;
        got = 0;
        lat = 0;
        for (int n = 1; n <= 20 && got == 0; n++) begin
            step();
            if (obs_valid) begin
                got = 1;
                lat = n;
            end
        end
    endtask

    vec_t vecs [10];

    initial begin
        int lat;
        int cnt;
        vecs[0] = '{32'd7,         32'hFFFF_FFFD, 2'd0, 32'hFFFF_FFEB};
        vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 32'h8000_0000};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 32'h8000_0000};
        vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 32'h7FFF_FFFF};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000};
        vecs[6] = '{32'hFFFF_FFFF, 32'd1,         2'd1, 32'hFFFF_FFFF};
        vecs[7] = '{32'd3,         32'd5,         2'd0, 32'h0000_000F};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 32'hFFFF_FFFE};
        vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFF};

        n_checks = 0;
        n_fail   = 0;
        m_rr     = 0;
        m_cycle  = 0;
        reset    = 1'b1;
        quiet();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Single operations on port 0, one at a time
        for (int v = 0; v < 10; v++) begin
            quiet();
            set_req(0, vecs[v].opa, vecs[v].opb, vecs[v].func, 6'(v * 5 + 1), 5'(v * 3 + 2));
            step();
            check("vec_grant", 64'(obs_ready), 64'(2'b01));
            quiet();
            wait_result(lat);
            check("vec_latency", 64'(lat), 64'd9);
            check("vec_value", 64'(obs_value), 64'(vecs[v].expv));
            check("vec_prf", 64'(obs_prf), 64'(v * 5 + 1));
            check("vec_rob", 64'(obs_rob), 64'(v * 3 + 2));
            step();
            check("vec_busy_fall", 64'(obs_busy), 64'd0);
        end

        // Both ports requesting: pointer sits at 1 after the port-0-only traffic
        for (int i = 0; i < 12; i++) begin
            rand_req(1);
            step();
            check("alt_grant", 64'(obs_ready), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
        end
        quiet();
        repeat (15) step();

        // CDB backpressure: credit stops issue at exactly FIFO_DEPTH
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            rand_req(1);
            bus.cdb_grant = 1'b0;
            step();
            if (obs_ready != 2'b00) cnt++;
        end
        check("bp_accepted", 64'(cnt), 64'(FIFO_DEPTH));
        check("bp_stalled", 64'(obs_ready), 64'd0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            rand_req(1);
            bus.cdb_grant = 1'b1;
            step();
            if (obs_ready != 2'b00) cnt++;
        end
        check("bp_resumed", 64'(cnt > 0), 64'd1);
        quiet();
        repeat (25) step();
        check("bp_drained", 64'(obs_busy), 64'd0);

        // Squash with 3 results buffered and 5 still in the multiplier
        for (int c = 0; c < 11; c++) begin
            quiet();
            bus.cdb_grant = 1'b0;
            if (c < 3 || c >= 6) set_req(0, rand_operand(), rand_operand(),
                                         2'($urandom_range(0, 3)), 6'(c), 5'(c));
            step();
        end
        quiet();
        bus.cdb_grant = 1'b0;
        bus.squash    = 1'b1;
        step();
        check("sq_buffered", 64'(obs_valid), 64'd1);
        quiet();
        set_req(0, vecs[0].opa, vecs[0].opb, vecs[0].func, 6'd33, 5'd17);
        step();
        check("sq_cdb_clear", 64'(obs_valid), 64'd0);
        check("sq_busy_clear", 64'(obs_busy), 64'd0);
        check("sq_new_grant", 64'(obs_ready), 64'(2'b01));
        quiet();
        wait_result(lat);
        check("sq_new_latency", 64'(lat), 64'd9);
        check("sq_new_value", 64'(obs_value), 64'(vecs[0].expv));
        check("sq_new_prf", 64'(obs_prf), 64'd33);
        repeat (5) step();

        // Reset in the middle of traffic
        for (int i = 0; i < 30; i++) begin
            rand_req(0);
            step();
        end
        rand_req(1);
        reset = 1'b1;
        step();
        check("rst_no_grant", 64'(obs_ready), 64'd0);
        reset = 1'b0;
        rand_req(1);
        step();
        check("rst_rr_zero", 64'(obs_ready), 64'(2'b01));
        check("rst_cdb_valid", 64'(obs_valid), 64'd0);
        check("rst_busy", 64'(obs_busy), 64'd0);
        quiet();
        repeat (12) step();

        // Randomised traffic with backpressure, squashes and resets
        for (int i = 0; i < 800; i++) begin
            rand_req(0);
            bus.cdb_grant = ($urandom_range(0, 3) != 0);
            bus.squash    = ($urandom_range(0, 63) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        quiet();
        repeat (30) step();
        check("final_idle", 64'(obs_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
